// File: rtl/spi_bridge_pkg.sv
// Shared types and constants for the SPI byte-to-register-bus bridge.
// Holds the FSM state encoding, command byte layout and the read error fill value.
package spi_bridge_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        CMD     = 2'd1,
        WR_DATA = 2'd2,
        RD_DATA = 2'd3
    } state_t;

    localparam int         ADDR_W     = 7;
    localparam int         CMD_WR_BIT = 7;
    localparam int         ADDR_MSB   = 6;
    localparam logic [7:0] ERR_FILL   = 8'hFF;

    // Limit is one bit wider than the address so a limit of 128 admits every address.
    function automatic logic addr_in_range(input logic [ADDR_W-1:0] addr,
                                           input logic [ADDR_W:0]   limit);
        return {1'b0, addr} < limit;
    endfunction

endpackage

// File: rtl/spi_reg_bridge_if.sv
// Register bus between the SPI bridge (master) and the register file (slave).
// Write/read strobes are single-cycle; read data returns one cycle after the read strobe.
interface spi_reg_bridge_if;

    logic [spi_bridge_pkg::ADDR_W-1:0] bus_addr;
    logic [7:0]                        bus_wdata;
    logic                              bus_wr;
    logic                              bus_rd;
    logic [7:0]                        bus_rdata;

    modport master (
        output bus_addr,
        output bus_wdata,
        output bus_wr,
        output bus_rd,
        input  bus_rdata
    );

    modport slave (
        input  bus_addr,
        input  bus_wdata,
        input  bus_wr,
        input  bus_rd,
        output bus_rdata
    );

endinterface

// File: rtl/spi_reg_bridge.sv
// Decodes SPI command/data byte frames into auto-incrementing register bus accesses
// and supplies the next transmit byte (status, write echo or read data) to the shift stage.
module spi_reg_bridge
    import spi_bridge_pkg::*;
#(
    parameter logic [7:0]      STATUS_BYTE = 8'h5A,
    parameter logic [ADDR_W:0] ADDR_LIMIT  = 8'd64
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    ena,
    input  logic                    ss,
    input  logic                    byte_valid,
    input  logic [7:0]              rx_byte,
    output logic [7:0]              tx_byte,
    output logic                    err,
    output logic                    frame_active,
    spi_reg_bridge_if.master        bus
);

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [ADDR_W-1:0] next_addr;
    logic [7:0]        wdata_q, wdata_d;
    logic [7:0]        tx_q, tx_d;
    logic              wr_q, wr_d;
    logic              rd_q, rd_d;
    logic              rd_oor_q, rd_oor_d;
    logic              cap_q, cap_d;
    logic              fill_q, fill_d;
    logic              inc_q, inc_d;
    logic              err_q, err_d;
    logic              active_q, active_d;
    logic              accept;

    assign accept    = byte_valid & ena & ~ss;
    assign next_addr = addr_q + 7'd1;

    // Writes increment the address one cycle late so the write strobe still sees the
    // address it targets; reads increment at once so the prefetch uses the new address.
    always_comb begin
        state_d  = state_q;
        addr_d   = inc_q ? next_addr : addr_q;
        wdata_d  = wdata_q;
        wr_d     = 1'b0;
        rd_d     = 1'b0;
        rd_oor_d = 1'b0;
        cap_d    = rd_q;
        fill_d   = rd_oor_q;
        inc_d    = 1'b0;
        err_d    = err_q;
        active_d = active_q;
        tx_d     = cap_q ? bus.bus_rdata : (fill_q ? ERR_FILL : tx_q);

        case (state_q)
            IDLE: begin
                if (!ss) begin
                    state_d = CMD;
                end
            end
            CMD: begin
                if (accept) begin
                    addr_d   = rx_byte[ADDR_MSB:0];
                    err_d    = 1'b0;
                    active_d = 1'b1;
                    if (rx_byte[CMD_WR_BIT]) begin
                        state_d = WR_DATA;
                    end else begin
                        state_d = RD_DATA;
                        if (addr_in_range(rx_byte[ADDR_MSB:0], ADDR_LIMIT)) begin
                            rd_d = 1'b1;
                        end else begin
                            rd_oor_d = 1'b1;
                            err_d    = 1'b1;
                        end
                    end
                end
            end
            WR_DATA: begin
                if (accept) begin
                    inc_d = 1'b1;
                    if (addr_in_range(addr_q, ADDR_LIMIT)) begin
                        wr_d    = 1'b1;
                        wdata_d = rx_byte;
                        tx_d    = rx_byte;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            RD_DATA: begin
                if (accept) begin
                    addr_d = next_addr;
                    if (addr_in_range(next_addr, ADDR_LIMIT)) begin
                        rd_d = 1'b1;
                    end else begin
                        rd_oor_d = 1'b1;
                        err_d    = 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        // Deselect aborts the frame; strobes already registered are left to finish.
        if (ss) begin
            state_d  = IDLE;
            active_d = 1'b0;
            tx_d     = STATUS_BYTE;
            cap_d    = 1'b0;
            fill_d   = 1'b0;
            rd_oor_d = 1'b0;
        end
    end

    // Reset overrides the clock enable; with ena low everything holds so pending
    // strobes are deferred rather than lost.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q  <= IDLE;
            addr_q   <= '0;
            wdata_q  <= '0;
            tx_q     <= STATUS_BYTE;
            wr_q     <= 1'b0;
            rd_q     <= 1'b0;
            rd_oor_q <= 1'b0;
            cap_q    <= 1'b0;
            fill_q   <= 1'b0;
            inc_q    <= 1'b0;
            err_q    <= 1'b0;
            active_q <= 1'b0;
        end else if (ena) begin
            state_q  <= state_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            tx_q     <= tx_d;
            wr_q     <= wr_d;
            rd_q     <= rd_d;
            rd_oor_q <= rd_oor_d;
            cap_q    <= cap_d;
            fill_q   <= fill_d;
            inc_q    <= inc_d;
            err_q    <= err_d;
            active_q <= active_d;
        end
    end

    assign bus.bus_addr  = addr_q;
    assign bus.bus_wdata = wdata_q;
    assign bus.bus_wr    = wr_q & ena;
    assign bus.bus_rd    = rd_q & ena;
    assign tx_byte       = tx_q;
    assign err           = err_q;
    assign frame_active  = active_q;

endmodule

// File: tb/tb_spi_reg_bridge.sv
// Scoreboard bench for spi_reg_bridge: two instances (address limits 64 and 128) share
// one byte stream; expected bus strobes and transmit bytes are queued per instance.
module tb_spi_reg_bridge;

    localparam logic [7:0] STATUS  = 8'h5A;
    localparam logic [7:0] LIMIT_A = 8'd64;
    localparam logic [7:0] LIMIT_B = 8'd128;

    typedef struct packed {
        logic       is_wr;
        logic [6:0] addr;
        logic [7:0] data;
    } bus_ev_t;

    typedef struct packed {
        logic       chk;
        logic [7:0] val;
    } tx_ev_t;

    logic       clk = 1'b0;
    logic       rst;
    logic       ena;
    logic       ss;
    logic       byte_valid;
    logic [7:0] rx_byte;
    logic [7:0] tx_a, tx_b;
    logic       err_a, err_b, fa_a, fa_b;

    int n_checks = 0;
    int n_pass   = 0;

    bus_ev_t bus_qa[$];
    bus_ev_t bus_qb[$];
    tx_ev_t  tx_qa[$];
    tx_ev_t  tx_qb[$];
    logic    exp_err[2];

    spi_reg_bridge_if if_a();
    spi_reg_bridge_if if_b();

    spi_reg_bridge #(.STATUS_BYTE(STATUS), .ADDR_LIMIT(LIMIT_A)) dut_a (
        .clk(clk), .rst(rst), .ena(ena), .ss(ss), .byte_valid(byte_valid),
        .rx_byte(rx_byte), .tx_byte(tx_a), .err(err_a), .frame_active(fa_a), .bus(if_a)
    );

    spi_reg_bridge #(.STATUS_BYTE(STATUS), .ADDR_LIMIT(LIMIT_B)) dut_b (
        .clk(clk), .rst(rst), .ena(ena), .ss(ss), .byte_valid(byte_valid),
        .rx_byte(rx_byte), .tx_byte(tx_b), .err(err_b), .frame_active(fa_b), .bus(if_b)
    );

    always #5 clk = ~clk;

    // Register file contents as a fixed ROM: address 5 reads A0, 6 reads A1.
    function automatic logic [7:0] rdataOf(input logic [6:0] a);
        return 8'({1'b0, a} + 8'h9B);
    endfunction

    function automatic logic inRange(input logic [6:0] a, input logic [7:0] lim);
        return {1'b0, a} < lim;
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] actual,
                               input logic [31:0] expected);
        n_checks++;
        if (actual === expected) begin
            n_pass++;
        end else begin
            $display("[TB] FAIL %s: got %0h, expected %0h", tag, actual, expected);
        end
    endtask

    // Read data is driven only in the cycle after a read strobe; EE elsewhere exposes mistimed capture.
    initial begin
        if_a.bus_rdata = 8'hEE;
        if_b.bus_rdata = 8'hEE;
    end

    always @(posedge clk) begin
        if_a.bus_rdata <= if_a.bus_rd ? rdataOf(if_a.bus_addr) : 8'hEE;
        if_b.bus_rdata <= if_b.bus_rd ? rdataOf(if_b.bus_addr) : 8'hEE;
    end

    bus_ev_t ev_a, ev_b;
    tx_ev_t  tev_a, tev_b;

    always @(negedge clk) begin
        if (if_a.bus_wr || if_a.bus_rd) begin
            if (bus_qa.size() == 0) begin
                checkOutput("a_extra_strobe", 32'({if_a.bus_wr, if_a.bus_rd}), 32'd0);
            end else begin
                ev_a = bus_qa.pop_front();
                checkOutput("a_strobe_kind", 32'({if_a.bus_wr, if_a.bus_rd}),
                            ev_a.is_wr ? 32'd2 : 32'd1);
                checkOutput("a_addr", 32'(if_a.bus_addr), 32'(ev_a.addr));
                if (ev_a.is_wr) checkOutput("a_wdata", 32'(if_a.bus_wdata), 32'(ev_a.data));
            end
        end
        if (if_b.bus_wr || if_b.bus_rd) begin
            if (bus_qb.size() == 0) begin
                checkOutput("b_extra_strobe", 32'({if_b.bus_wr, if_b.bus_rd}), 32'd0);
            end else begin
                ev_b = bus_qb.pop_front();
                checkOutput("b_strobe_kind", 32'({if_b.bus_wr, if_b.bus_rd}),
                            ev_b.is_wr ? 32'd2 : 32'd1);
                checkOutput("b_addr", 32'(if_b.bus_addr), 32'(ev_b.addr));
                if (ev_b.is_wr) checkOutput("b_wdata", 32'(if_b.bus_wdata), 32'(ev_b.data));
            end
        end
        if (byte_valid && ena && !ss) begin
            if (tx_qa.size() == 0) begin
                checkOutput("a_tx_missing", 32'd0, 32'd1);
            end else begin
                tev_a = tx_qa.pop_front();
                if (tev_a.chk) checkOutput("a_tx", 32'(tx_a), 32'(tev_a.val));
            end
            if (tx_qb.size() == 0) begin
                checkOutput("b_tx_missing", 32'd0, 32'd1);
            end else begin
                tev_b = tx_qb.pop_front();
                if (tev_b.chk) checkOutput("b_tx", 32'(tx_b), 32'(tev_b.val));
            end
        end
    end

    task automatic pushBus(input int k, input bus_ev_t e);
        if (k == 0) bus_qa.push_back(e);
        else        bus_qb.push_back(e);
    endtask

    task automatic pushTx(input int k, input tx_ev_t e);
        if (k == 0) tx_qa.push_back(e);
        else        tx_qb.push_back(e);
    endtask

    task automatic sendByte(input logic [7:0] b, input logic abort, input logic defer);
        @(posedge clk); #1;
        rx_byte    = b;
        byte_valid = 1'b1;
        if (abort) ss = 1'b1;
        @(posedge clk); #1;
        byte_valid = 1'b0;
        rx_byte    = 8'($urandom);
        if (abort) begin
            checkOutput("abort_fa_a", 32'(fa_a), 32'd0);
            checkOutput("abort_fa_b", 32'(fa_b), 32'd0);
        end
        if (defer) begin
            ena = 1'b0;
            #1;
            checkOutput("defer_gate_a", 32'(if_a.bus_wr), 32'd0);
            repeat (3) @(posedge clk);
            #1;
            ena = 1'b1;
        end
        repeat (5) @(posedge clk);
    endtask

    // Builds the expected strobes/tx bytes for both limits, then drives the frame.
    task automatic applyStimulus(input logic [7:0] cmd, input logic [7:0] d [3],
                                 input int n, input int abort_at, input logic defer);
        logic aborted;
        for (int k = 0; k < 2; k++) begin
            logic [7:0] lim;
            logic [6:0] a;
            logic       oor;
            logic       have_w;
            logic [7:0] last_w;
            logic [7:0] rd_val;
            lim    = (k == 0) ? LIMIT_A : LIMIT_B;
            a      = cmd[6:0];
            oor    = 1'b0;
            have_w = 1'b0;
            last_w = 8'h00;
            rd_val = 8'hFF;
            pushTx(k, '{chk: 1'b1, val: STATUS});
            if (!cmd[7]) begin
                if (inRange(a, lim)) begin
                    pushBus(k, '{is_wr: 1'b0, addr: a, data: 8'h00});
                    rd_val = rdataOf(a);
                end else begin
                    oor = 1'b1;
                end
            end
            for (int i = 0; i < n; i++) begin
                if (abort_at == i + 1) break;
                if (cmd[7]) begin
                    pushTx(k, '{chk: have_w, val: last_w});
                    if (inRange(a, lim)) begin
                        pushBus(k, '{is_wr: 1'b1, addr: a, data: d[i]});
                        have_w = 1'b1;
                        last_w = d[i];
                    end else begin
                        oor = 1'b1;
                    end
                    a = a + 7'd1;
                end else begin
                    pushTx(k, '{chk: 1'b1, val: rd_val});
                    a = a + 7'd1;
                    if (inRange(a, lim)) begin
                        pushBus(k, '{is_wr: 1'b0, addr: a, data: 8'h00});
                        rd_val = rdataOf(a);
                    end else begin
                        oor    = 1'b1;
                        rd_val = 8'hFF;
                    end
                end
            end
            exp_err[k] = oor;
        end

        @(posedge clk); #1;
        ss = 1'b0;
        repeat (2) @(posedge clk);
        sendByte(cmd, 1'b0, 1'b0);
        aborted = 1'b0;
        for (int i = 0; i < n; i++) begin
            sendByte(d[i], abort_at == i + 1, defer);
            if (abort_at == i + 1) begin
                aborted = 1'b1;
                break;
            end
        end

        if (!aborted) begin
            repeat (2) @(posedge clk); #1;
            checkOutput("fa_a", 32'(fa_a), 32'd1);
            checkOutput("fa_b", 32'(fa_b), 32'd1);
            checkOutput("err_a", 32'(err_a), 32'(exp_err[0]));
            checkOutput("err_b", 32'(err_b), 32'(exp_err[1]));
            ss = 1'b1;
            @(posedge clk); #1;
            checkOutput("end_fa_a", 32'(fa_a), 32'd0);
            checkOutput("end_tx_a", 32'(tx_a), 32'(STATUS));
        end
        checkOutput("hold_err_a", 32'(err_a), 32'(exp_err[0]));
        checkOutput("hold_err_b", 32'(err_b), 32'(exp_err[1]));
        repeat (2) @(posedge clk);
    endtask

    task automatic checkResetValues(input string phase);
        checkOutput({phase, "_tx_a"}, 32'(tx_a), 32'(STATUS));
        checkOutput({phase, "_addr_a"}, 32'(if_a.bus_addr), 32'd0);
        checkOutput({phase, "_wdata_a"}, 32'(if_a.bus_wdata), 32'd0);
        checkOutput({phase, "_strobes_a"}, 32'({if_a.bus_wr, if_a.bus_rd}), 32'd0);
        checkOutput({phase, "_err_a"}, 32'(err_a), 32'd0);
        checkOutput({phase, "_fa_a"}, 32'(fa_a), 32'd0);
        checkOutput({phase, "_addr_b"}, 32'(if_b.bus_addr), 32'd0);
        checkOutput({phase, "_tx_b"}, 32'(tx_b), 32'(STATUS));
    endtask

    initial begin
        #2_000_000;
        $display("[TB] FAIL timeout: bench did not reach its end");
        $fatal(1, "[TB] timeout");
    end

    initial begin
        rst        = 1'b0;
        ena        = 1'b1;
        ss         = 1'b1;
        byte_valid = 1'b0;
        rx_byte    = 8'h00;
        repeat (3) @(posedge clk); #1;
        checkResetValues("reset");
        rst = 1'b1;
        repeat (2) @(posedge clk);

        $display("[TB] write frame 83 11 22");
        applyStimulus(8'h83, '{8'h11, 8'h22, 8'h00}, 2, 0, 1'b0);

        $display("[TB] read frame 05 xx xx");
        applyStimulus(8'h05, '{8'($urandom), 8'($urandom), 8'h00}, 2, 0, 1'b0);

        $display("[TB] range frame BF 77 66");
        applyStimulus(8'hBF, '{8'h77, 8'h66, 8'h00}, 2, 0, 1'b0);

        $display("[TB] wrap read 7F xx");
        applyStimulus(8'h7F, '{8'($urandom), 8'h00, 8'h00}, 1, 0, 1'b0);

        $display("[TB] abort on second data byte");
        applyStimulus(8'h90, '{8'h44, 8'h45, 8'h00}, 2, 2, 1'b0);

        $display("[TB] write deferred by ena low");
        applyStimulus(8'hA0, '{8'h55, 8'h00, 8'h00}, 1, 0, 1'b1);

        $display("[TB] reset during read with strobe pending");
        pushTx(0, '{chk: 1'b1, val: STATUS});
        pushTx(1, '{chk: 1'b1, val: STATUS});
        @(posedge clk); #1;
        ss = 1'b0;
        repeat (2) @(posedge clk); #1;
        rx_byte    = 8'h08;
        byte_valid = 1'b1;
        @(posedge clk); #1;
        byte_valid = 1'b0;
        ena        = 1'b0;
        rst        = 1'b0;
        @(posedge clk); #1;
        checkResetValues("midreset");
        rst = 1'b1;
        ena = 1'b1;
        repeat (4) @(posedge clk); #1;
        ss = 1'b1;
        repeat (3) @(posedge clk); #1;

        checkOutput("sb_bus_a_empty", 32'(bus_qa.size()), 32'd0);
        checkOutput("sb_bus_b_empty", 32'(bus_qb.size()), 32'd0);
        checkOutput("sb_tx_a_empty", 32'(tx_qa.size()), 32'd0);
        checkOutput("sb_tx_b_empty", 32'(tx_qb.size()), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/spi_reg_bridge.md
# spi_reg_bridge

Byte-level command decoder that sits directly downstream of the SPI slave shift stage. It consumes each completed receive byte and its one-cycle byte strobe, and decodes frames of one command byte followed by data bytes into single-cycle register-bus write and read strobes with an auto-incrementing address. It supplies the next transmit byte back to the shift stage's parallel load input, so read data is shifted out on the following byte.

## Interface
- `STATUS_BYTE`, default `8'h5A`: byte returned during the command byte of every frame.
- `ADDR_LIMIT`, default `7'd64`: first invalid address. Accesses at or above it are suppressed and flagged.
- `clk`  in  1  shared clock with the SPI shift stage; all logic on rising edge.
- `rst`  in  1  synchronous, active-low reset.
- `ena`  in  1  clock enable, same signal as the shift stage. When low, state and outputs hold; strobes are forced low.
- `ss`  in  1  slave select, active-high deselect. High means idle and aborts the frame.
- `byte_valid`  in  1  one-cycle strobe from the shift stage; the byte completes on this edge.
- `rx_byte`  in  8  received byte, valid while `byte_valid` is high.
- `tx_byte`  out  8  next byte to load into the shift stage; must be stable whenever `byte_valid` is high.
- `bus_addr`  out  7  register address.
- `bus_wdata`  out  8  write data.
- `bus_wr`  out  1  one-cycle write strobe.
- `bus_rd`  out  1  one-cycle read strobe.
- `bus_rdata`  in  8  read data, valid exactly one cycle after `bus_rd`.
- `err`  out  1  address-range error; sticky within a frame.
- `frame_active`  out  1  high from the first accepted command byte until `ss` goes high.

## Operation
- Command byte: bit 7 = 1 means write, 0 means read. Bits 6:0 are the start address.
- States: `IDLE`, `CMD`, `WR_DATA`, `RD_DATA`.
  - `IDLE` → `CMD` when `ss` is low.
  - `CMD` → `WR_DATA` or `RD_DATA` on an accepted command byte.
  - Any state → `IDLE` when `ss` is high.
- A byte is accepted when `byte_valid & ena & ~ss` on a rising edge.
- Command accept:
  - Latch the address into `bus_addr` and clear `err`.
  - Set `frame_active`.
- Write frame, each accepted data byte:
  - If `bus_addr < ADDR_LIMIT`: `bus_wdata` takes `rx_byte` and `bus_wr` pulses in the next cycle with the current address.
  - Otherwise: no strobe; `err` is set.
  - Then the address increments.
- Read frame:
  - On command accept, `bus_rd` pulses in the next cycle at the start address.
  - `bus_rdata` is captured into `tx_byte` one cycle after the `bus_rd` pulse.
  - After each accepted byte in `RD_DATA`, the address increments and the next `bus_rd` is issued.
  - Bytes received in `RD_DATA` are ignored.
- Out-of-range read: no `bus_rd`; `tx_byte` takes `8'hFF`; `err` is set.
- Address width: 7-bit arithmetic, wrapping from 127 to 0. Range is checked after wrap.
- `tx_byte`:
  - Equals `STATUS_BYTE` in `IDLE` and `CMD`.
  - In `WR_DATA`, echoes the last written byte.
  - In `RD_DATA`, holds the captured read data.

## Timing
- Reset values: `tx_byte` = `STATUS_BYTE`; `bus_addr`, `bus_wdata`, `bus_wr`, `bus_rd`, `err` and `frame_active` all 0; state `IDLE`.
- Write latency: the `bus_wr` pulse is registered and asserts one cycle after the accepting edge.
- Read latency: `bus_rd` asserts 1 cycle after the accepting edge; `tx_byte` updates 2 cycles after it. This is well inside the 8-cycle byte period.
- `ss` high in the same cycle as `byte_valid`: `ss` wins. The byte is dropped and no strobe is issued.
- `ss` high mid-frame:
  - Pending strobes already registered still complete.
  - No new strobes; state goes to `IDLE`; `frame_active` is cleared next edge.
  - `err` holds until the next command.
- Reset low mid-frame: all outputs return to reset values on that edge; pending strobes are cancelled.
- `ena` low: a strobe scheduled for that cycle is deferred until `ena` returns high, not lost.

## Structure
- Shared package `spi_bridge_pkg` holds:
  - the state enum;
  - the command bit positions (`CMD_WR_BIT` = 7, address field 6:0);
  - the `8'hFF` error fill constant.
- Single module. The FSM, the address counter and the tx mux are all inline; no sub-module is warranted.

## Test plan
- Write frame: `ss` low, bytes `8'h83, 8'h11, 8'h22` → `bus_wr` at address 3 with data `11`, then at address 4 with data `22`; `err` = 0; `tx_byte` = `5A` during the command byte.
- Read frame: `ss` low, bytes `8'h05, xx, xx`, with `bus_rdata` returning `A0`/`A1` → `bus_rd` at 5, then 6; the shift stage sees `5A`, `A0`, `A1`.
- Range error with `ADDR_LIMIT` = 64: write frame `8'hBF, 8'h77, 8'h66` → `bus_wr` at 63 only; `err` = 1; the next frame's command clears `err`.
- Wrap: read frame `8'h7F` with `ADDR_LIMIT` = 128 → reads at 127, then 0.
- Abort: `ss` high in the same cycle as the second data byte's `byte_valid` → that byte produces no strobe; state is `IDLE` and `frame_active` = 0 next cycle.
- Reset low during `RD_DATA` with `bus_rd` pending → no strobe; all outputs at reset values one edge later.
